// File: rtl/noise_acq_pkg.sv
// Shared definitions for the noise acquisition sequencer.
// Holds the register map, FSM state encoding, pattern bit positions and the
// phase table entry layout used by noise_acq_sequencer and noise_acq_div.
package noise_acq_pkg;

  localparam int DUR_W = 16;
  localparam int PAT_W = 4;
  localparam int CNT_W = 16;

  localparam logic [2:0] ADDR_CTRL  = 3'd0;
  localparam logic [2:0] ADDR_IDX   = 3'd1;
  localparam logic [2:0] ADDR_DUR   = 3'd2;
  localparam logic [2:0] ADDR_PAT   = 3'd3;
  localparam logic [2:0] ADDR_DIV   = 3'd4;
  localparam logic [2:0] ADDR_LOOPS = 3'd5;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int PAT_SW_ACQ1    = 0;
  localparam int PAT_SW_ACQ2    = 1;
  localparam int PAT_SD_ACQ_EN  = 2;
  localparam int PAT_ACQ_CLK_EN = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DUR_W-1:0] dur;
    logic [PAT_W-1:0] pat;
  } phase_entry_t;

endpackage

// File: rtl/noise_acq_div.sv
// ADC acquisition strobe divider.
// Emits a pulse on the first enabled cycle after a restart, then every
// i_div+1 enabled cycles. i_div = 0 pulses on every enabled cycle.
// Ports:
//   i_clk_sys  system clock
//   i_rst_n    synchronous active-low reset
//   i_restart  rearm so the next enabled cycle pulses
//   i_en       divider advances only while high
//   i_div      divide value
//   o_pulse    one-cycle strobe
module noise_acq_div
  import noise_acq_pkg::*;
(
  input  logic             i_clk_sys,
  input  logic             i_rst_n,
  input  logic             i_restart,
  input  logic             i_en,
  input  logic [DUR_W-1:0] i_div,
  output logic             o_pulse
);

  logic [DUR_W-1:0] r_cnt;

  // Down-counter: terminal count 0 fires the strobe and reloads i_div.
  assign o_pulse = i_en && (r_cnt == '0);

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == '0) r_cnt <= i_div;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/noise_acq_sequencer.sv
// Table-driven phase sequencer for noise acquisition.
// The DSP loads phase durations/patterns via the write decode, then a start
// command walks the table driving the acquisition switches and the ADC
// sample strobe, finishing with a one-cycle done interrupt.
// Optional feature macro: NOISE_ACQ_LOOP_EN adds the LOOPS register
// (address 5) which repeats the whole table LOOPS extra times.
// Ports:
//   i_clk_sys              system clock
//   i_rst_n                synchronous active-low reset
//   i_wr_en/addr/data      register write strobe, select, data
//   o_sw_acq1/o_sw_acq2    pattern bits 0/1
//   o_sd_acq_en            pattern bit 2
//   o_acq_clk              one-cycle ADC sample strobe
//   o_busy                 sequence in progress
//   o_phase_idx            current phase
//   o_sample_cnt           saturating count of o_acq_clk pulses since start
//   o_done_irq             one-cycle pulse on normal completion
//   o_aborted              sticky abort flag, cleared by an accepted start
//
// state | meaning
// IDLE  | waiting for start
// FETCH | loading the current phase duration, outputs 0
// RUN   | driving the phase pattern for dur cycles
// DONE  | done_irq pulse, then IDLE
module noise_acq_sequencer
  import noise_acq_pkg::*;
#(
  parameter int NPHASE = 8
) (
  input  logic                      i_clk_sys,
  input  logic                      i_rst_n,
  input  logic                      i_wr_en,
  input  logic [2:0]                i_wr_addr,
  input  logic [15:0]               i_wr_data,
  output logic                      o_sw_acq1,
  output logic                      o_sw_acq2,
  output logic                      o_sd_acq_en,
  output logic                      o_acq_clk,
  output logic                      o_busy,
  output logic [$clog2(NPHASE)-1:0] o_phase_idx,
  output logic [CNT_W-1:0]          o_sample_cnt,
  output logic                      o_done_irq,
  output logic                      o_aborted
);

  localparam int              PH_W    = $clog2(NPHASE);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NPHASE - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  phase_entry_t     r_table [NPHASE];
  phase_entry_t     w_cur;
  logic [PH_W-1:0]  r_idx;
  logic [PH_W-1:0]  r_phase;
  logic [DUR_W-1:0] r_div;
  logic [DUR_W-1:0] r_dur_cnt;
  logic [CNT_W-1:0] r_sample_cnt;
  logic             r_aborted;

  logic w_ctrl_wr;
  logic w_start;
  logic w_abort;
  logic w_cfg_wr;
  logic w_busy;
  logic w_run;
  logic w_done;
  logic w_seq_start;
  logic w_phase_inc;
  logic w_loop_again;
  logic w_loop_pending;
  logic w_acq_clk;

  assign w_cur     = r_table[r_phase];
  assign w_ctrl_wr = i_wr_en && (i_wr_addr == ADDR_CTRL);
  assign w_abort   = w_ctrl_wr && i_wr_data[CTRL_ABORT_BIT];
  // Abort takes priority over a start in the same write.
  assign w_start   = w_ctrl_wr && i_wr_data[CTRL_START_BIT] && !i_wr_data[CTRL_ABORT_BIT];
  assign w_cfg_wr  = i_wr_en && !w_busy;

  always_comb begin
    w_state_nxt  = r_state;
    w_seq_start  = 1'b0;
    w_phase_inc  = 1'b0;
    w_loop_again = 1'b0;
    w_busy       = 1'b0;
    w_run        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_FETCH;
          w_seq_start = 1'b1;
        end
      end
      ST_FETCH: begin
        w_busy = 1'b1;
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cur.dur == '0) begin
          // dur == 0 is the end-of-table marker
          if (w_loop_pending) begin
            w_loop_again = 1'b1;
            w_state_nxt  = ST_FETCH;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        w_run  = 1'b1;
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_dur_cnt == DUR_W'(1)) begin
          if (r_phase == LAST_PH) begin
            if (w_loop_pending) begin
              w_loop_again = 1'b1;
              w_state_nxt  = ST_FETCH;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_phase_inc = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NPHASE; i++) r_table[i] <= '0;
      r_idx <= '0;
      r_div <= '0;
    end else if (w_cfg_wr) begin
      case (i_wr_addr)
        ADDR_IDX: r_idx              <= i_wr_data[PH_W-1:0];
        ADDR_DUR: r_table[r_idx].dur <= i_wr_data;
        ADDR_PAT: r_table[r_idx].pat <= i_wr_data[PAT_W-1:0];
        ADDR_DIV: r_div              <= i_wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      r_phase      <= '0;
      r_dur_cnt    <= '0;
      r_sample_cnt <= '0;
      r_aborted    <= 1'b0;
    end else begin
      if (w_seq_start || w_loop_again) r_phase <= '0;
      else if (w_phase_inc)            r_phase <= r_phase + 1'b1;
      else if (w_state_nxt == ST_IDLE) r_phase <= '0;

      if (r_state == ST_FETCH)    r_dur_cnt <= w_cur.dur;
      else if (r_state == ST_RUN) r_dur_cnt <= r_dur_cnt - 1'b1;

      if (w_seq_start)
        r_sample_cnt <= '0;
      else if (w_acq_clk && (r_sample_cnt != '1))
        r_sample_cnt <= r_sample_cnt + 1'b1;

      if (w_abort)          r_aborted <= 1'b1;
      else if (w_seq_start) r_aborted <= 1'b0;
    end
  end

`ifdef NOISE_ACQ_LOOP_EN
  logic [15:0] r_loops;
  logic [15:0] r_loop_cnt;

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      r_loops    <= '0;
      r_loop_cnt <= '0;
    end else begin
      if (w_cfg_wr && (i_wr_addr == ADDR_LOOPS)) r_loops <= i_wr_data;
      if (w_seq_start)       r_loop_cnt <= r_loops;
      else if (w_loop_again) r_loop_cnt <= r_loop_cnt - 1'b1;
    end
  end

  assign w_loop_pending = (r_loop_cnt != '0);
`else
  assign w_loop_pending = 1'b0;
`endif

  // Not in RUN means rearm, so every phase starts with a strobe.
  noise_acq_div u_div (
    .i_clk_sys (i_clk_sys),
    .i_rst_n   (i_rst_n),
    .i_restart (!w_run),
    .i_en      (w_run && w_cur.pat[PAT_ACQ_CLK_EN]),
    .i_div     (r_div),
    .o_pulse   (w_acq_clk)
  );

  assign o_sw_acq1    = w_run && w_cur.pat[PAT_SW_ACQ1];
  assign o_sw_acq2    = w_run && w_cur.pat[PAT_SW_ACQ2];
  assign o_sd_acq_en  = w_run && w_cur.pat[PAT_SD_ACQ_EN];
  assign o_acq_clk    = w_acq_clk;
  assign o_busy       = w_busy;
  assign o_phase_idx  = r_phase;
  assign o_sample_cnt = r_sample_cnt;
  assign o_done_irq   = w_done;
  assign o_aborted    = r_aborted;

endmodule
